cpu_mem_arbiter: RTL and testbench

Shares one single-ported memory between the CPU instruction-fetch port (IM) and data port (DM). It sits between the CPU's `im_*`/`dm_*` interfaces and the memory wrapper. It serialises requests, holds completed results until the whole pipeline advances, and drives `im_wait_o`/`dm_wait_o`, which the CPU ORs into its global stall.

---
 rtl/cpu_mem_arbiter_pkg.sv | 25 ++
 rtl/cpu_mem_arbiter_if.sv | 45 ++++
 rtl/cpu_mem_arbiter_port_buf.sv | 52 +++++
 rtl/cpu_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types and constants for the CPU instruction/data memory arbiter.
package arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IM   = 2'd1,
        ARB_DM   = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_IM = 1'b0,
        GNT_DM = 1'b1
    } arb_grant_e;

    // Active-low byte enables: all ones means no byte is written (a read).
    localparam logic [3:0] BWEB_READ = 4'hF;

    function automatic logic bweb_is_read(input logic [3:0] bweb);
        return (bweb == BWEB_READ);
    endfunction

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// CPU-side (im_*/dm_*) and memory-side (mem_*) signals of the arbiter.
// slave  : the arbiter's view.
// master : the view of the surrounding CPU + memory wrapper.
interface cpu_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              im_request_i;
    logic [ADDR_W-1:0] im_pc_i;
    logic              im_wait_o;
    logic [ADDR_W-1:0] im_addr_o;
    logic [DATA_W-1:0] im_dout_o;

    logic              dm_request_i;
    logic [3:0]        dm_bit_write_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_din_i;
    logic              dm_wait_o;
    logic [DATA_W-1:0] dm_dout_o;

    logic              mem_req_o;
    logic [3:0]        mem_bweb_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ready_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  im_request_i, im_pc_i,
        output im_wait_o, im_addr_o, im_dout_o,
        input  dm_request_i, dm_bit_write_i, dm_addr_i, dm_din_i,
        output dm_wait_o, dm_dout_o,
        output mem_req_o, mem_bweb_o, mem_addr_o, mem_wdata_o,
        input  mem_ready_i, mem_rdata_i
    );

    modport master (
        output im_request_i, im_pc_i,
        input  im_wait_o, im_addr_o, im_dout_o,
        output dm_request_i, dm_bit_write_i, dm_addr_i, dm_din_i,
        input  dm_wait_o, dm_dout_o,
        input  mem_req_o, mem_bweb_o, mem_addr_o, mem_wdata_o,
        output mem_ready_i, mem_rdata_i
    );
endinterface

// File: rtl/cpu_mem_arbiter_port_buf.sv
// Per-port completion buffer: done flag plus the captured address/data that
// is held for the CPU until the whole pipeline advances.
module arb_port_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_request,
    input  logic              i_complete,
    input  logic              i_advance,
    input  logic              i_cap_data,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    logic              r_done;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    // Done flag set on completion, cleared on advance or when the request drops;
    // address/data captured on completion and held until the next one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_done <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            if (i_advance || !i_request) begin
                r_done <= 1'b0;
            end else if (i_complete) begin
                r_done <= 1'b1;
            end else begin
                r_done <= r_done;
            end
            if (i_complete) begin
                r_addr <= i_addr;
                if (i_cap_data) begin
                    r_data <= i_data;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates one single-ported memory between the CPU fetch (IM) and data (DM)
// ports. One transaction is outstanding at a time; results are held until both
// ports stop waiting. Optional macro ARB_RR_EN selects round-robin arbitration
// when both ports are eligible; otherwise DM has fixed priority over IM.
module cpu_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    cpu_mem_arbiter_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = ARB_IDLE;
    localparam logic [1:0] ST_IM   = ARB_IM;
    localparam logic [1:0] ST_DM   = ARB_DM;

    logic [1:0]        r_state;
    logic              r_mem_req;
    logic [3:0]        r_mem_bweb;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_im_done;
    logic              w_dm_done;
    logic              w_im_elig;
    logic              w_dm_elig;
    logic              w_im_wait;
    logic              w_dm_wait;
    logic              w_advance;
    logic              w_im_complete;
    logic              w_dm_complete;
    arb_grant_e        w_grant;
    logic [ADDR_W-1:0] w_im_addr;
    logic [DATA_W-1:0] w_im_data;
    logic [ADDR_W-1:0] w_dm_addr_unused;
    logic [DATA_W-1:0] w_dm_data;

    assign w_im_elig     = bus.im_request_i & ~w_im_done;
    assign w_dm_elig     = bus.dm_request_i & ~w_dm_done;
    assign w_im_wait     = w_im_elig;
    assign w_dm_wait     = w_dm_elig;
    assign w_advance     = ~w_im_wait & ~w_dm_wait;
    assign w_im_complete = (r_state == ST_IM) & bus.mem_ready_i;
    assign w_dm_complete = (r_state == ST_DM) & bus.mem_ready_i;

`ifdef ARB_RR_EN
    arb_grant_e r_last_grant;

    // Remember which port was granted last so a contended round goes to the other.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_grant <= GNT_IM;
        end else if ((r_state == ST_IDLE) && (w_im_elig || w_dm_elig)) begin
            r_last_grant <= w_grant;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    // Round-robin when both ports compete, otherwise whichever one is eligible.
    always_comb begin
        w_grant = GNT_IM;
        if (w_dm_elig && w_im_elig) begin
            w_grant = (r_last_grant == GNT_IM) ? GNT_DM : GNT_IM;
        end else if (w_dm_elig) begin
            w_grant = GNT_DM;
        end else begin
            w_grant = GNT_IM;
        end
    end
`else
    // Fixed priority: a data access always wins over a fetch.
    always_comb begin
        w_grant = GNT_IM;
        if (w_dm_elig) begin
            w_grant = GNT_DM;
        end else begin
            w_grant = GNT_IM;
        end
    end
`endif

    // Arbiter FSM: grant from IDLE, hold the memory request stable until ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_bweb  <= BWEB_READ;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_im_elig || w_dm_elig) begin
                        r_mem_req <= 1'b1;
                        if (w_grant == GNT_DM) begin
                            r_state     <= ST_DM;
                            r_mem_addr  <= bus.dm_addr_i;
                            r_mem_bweb  <= bus.dm_bit_write_i;
                            r_mem_wdata <= bus.dm_din_i;
                        end else begin
                            r_state     <= ST_IM;
                            r_mem_addr  <= bus.im_pc_i;
                            r_mem_bweb  <= BWEB_READ;
                            r_mem_wdata <= '0;
                        end
                    end
                end
                ST_IM, ST_DM: begin
                    if (bus.mem_ready_i) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    arb_port_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_im_buf (
        .clk        (clk),
        .rst        (rst),
        .i_request  (bus.im_request_i),
        .i_complete (w_im_complete),
        .i_advance  (w_advance),
        .i_cap_data (1'b1),
        .i_addr     (r_mem_addr),
        .i_data     (bus.mem_rdata_i),
        .o_done     (w_im_done),
        .o_addr     (w_im_addr),
        .o_data     (w_im_data)
    );

    // Write completions leave the held load data untouched.
    arb_port_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dm_buf (
        .clk        (clk),
        .rst        (rst),
        .i_request  (bus.dm_request_i),
        .i_complete (w_dm_complete),
        .i_advance  (w_advance),
        .i_cap_data (bweb_is_read(r_mem_bweb)),
        .i_addr     (r_mem_addr),
        .i_data     (bus.mem_rdata_i),
        .o_done     (w_dm_done),
        .o_addr     (w_dm_addr_unused),
        .o_data     (w_dm_data)
    );

    assign bus.im_wait_o   = w_im_wait;
    assign bus.dm_wait_o   = w_dm_wait;
    assign bus.im_addr_o   = w_im_addr;
    assign bus.im_dout_o   = w_im_data;
    assign bus.dm_dout_o   = w_dm_data;
    assign bus.mem_req_o   = r_mem_req;
    assign bus.mem_bweb_o  = r_mem_bweb;
    assign bus.mem_addr_o  = r_mem_addr;
    assign bus.mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter: a CPU-like driver issues rounds of
// fetch/data requests, a memory responder answers with chosen latencies, and
// two monitors compare memory transactions and held results against a
// reference computed from the arbitration rules.
module tb_cpu_mem_arbiter;
    import arb_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  bweb;
        logic [31:0] wdata;
        bit          is_dm;
    } txn_t;

    typedef struct {
        logic [31:0] im_dout;
        logic [31:0] im_addr;
        logic [31:0] dm_dout;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    txn_t exp_mem_q[$];
    res_t exp_res_q[$];
    int   lat_q[$];

    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ref_im_dout, ref_im_addr, ref_dm_dout;
    bit          ref_last_dm;

    bit   hold = 1'b0;
    bit   spur = 1'b0;
    bit   active = 1'b0;
    int   cnt = 0;
    bit   prev_req = 1'b0;
    txn_t cur_txn;
    res_t got_res;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] bweb,
                                          input logic [31:0] d);
        logic [31:0] w;
        w = old;
        for (int i = 0; i < 4; i++) begin
            if (!bweb[i]) w[8*i +: 8] = d[8*i +: 8];
        end
        return w;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : init_word(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory wrapper model: answer each request after its queued latency.
    initial begin
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.mem_ready_i) begin
                bus.mem_ready_i = 1'b0;
            end else if (bus.mem_req_o) begin
                if (!active) begin
                    active = 1'b1;
                    cnt = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                end
                if (!hold) begin
                    if (cnt == 0) begin
                        bus.mem_rdata_i = env_rd(bus.mem_addr_o);
                        if (bus.mem_bweb_o != BWEB_READ)
                            env_mem[bus.mem_addr_o] = merge(env_rd(bus.mem_addr_o),
                                                            bus.mem_bweb_o, bus.mem_wdata_o);
                        bus.mem_ready_i = 1'b1;
                        active = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end else begin
                active = 1'b0;
                if (spur) begin
                    spur = 1'b0;
                    bus.mem_rdata_i = 32'hBAD0BAD0;
                    bus.mem_ready_i = 1'b1;
                end
            end
        end
    end

    // Memory-side monitor: each new request must match the next expected transaction.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.mem_req_o && !prev_req) begin
                if (exp_mem_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mem_txn: unexpected request addr %h", bus.mem_addr_o);
                end else begin
                    cur_txn = exp_mem_q.pop_front();
                    chk("mem_addr", bus.mem_addr_o, cur_txn.addr);
                    chk("mem_bweb", {28'h0, bus.mem_bweb_o}, {28'h0, cur_txn.bweb});
                    if (cur_txn.is_dm) chk("mem_wdata", bus.mem_wdata_o, cur_txn.wdata);
                end
            end else if (bus.mem_req_o && prev_req) begin
                chk("mem_addr_stable", bus.mem_addr_o, cur_txn.addr);
            end
            prev_req = bus.mem_req_o;
        end
    end

    // CPU-side monitor: when a round's requests are all served, check held results.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && (bus.im_request_i || bus.dm_request_i) && !bus.im_wait_o && !bus.dm_wait_o) begin
                if (exp_res_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL res: unexpected completion");
                end else begin
                    got_res = exp_res_q.pop_front();
                    chk("im_dout", bus.im_dout_o, got_res.im_dout);
                    chk("im_addr", bus.im_addr_o, got_res.im_addr);
                    chk("dm_dout", bus.dm_dout_o, got_res.dm_dout);
                end
            end
        end
    end

    task automatic push_res();
        res_t r;
        r.im_dout = ref_im_dout;
        r.im_addr = ref_im_addr;
        r.dm_dout = ref_dm_dout;
        exp_res_q.push_back(r);
    endtask

    task automatic wait_round(output int cyc);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            if (!bus.im_wait_o && !bus.dm_wait_o) break;
            cyc++;
            if (cyc > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL round_timeout: waits still high after %0d cycles", cyc);
                break;
            end
        end
    endtask

    // One CPU round: both requests raised together, held until both waits drop.
    task automatic run_round(input bit im_en, input logic [31:0] pc, input bit dm_en,
                             input logic [31:0] da, input logic [3:0] bw,
                             input logic [31:0] din, input int la, input int lb,
                             input bit chk_cyc);
        txn_t ti, td;
        bit   dm_first;
        int   cyc;
        int   exp_cyc;
        ti = '{pc, BWEB_READ, 32'h0, 1'b0};
        td = '{da, bw, din, 1'b1};
        if (im_en && dm_en) begin
`ifdef ARB_RR_EN
            dm_first = !ref_last_dm;
`else
            dm_first = 1'b1;
`endif
            if (dm_first) begin
                exp_mem_q.push_back(td); exp_mem_q.push_back(ti); ref_last_dm = 1'b0;
            end else begin
                exp_mem_q.push_back(ti); exp_mem_q.push_back(td); ref_last_dm = 1'b1;
            end
            lat_q.push_back(la); lat_q.push_back(lb);
            exp_cyc = 4 + la + lb;
        end else if (dm_en) begin
            exp_mem_q.push_back(td); lat_q.push_back(la); ref_last_dm = 1'b1;
            exp_cyc = 2 + la;
        end else if (im_en) begin
            exp_mem_q.push_back(ti); lat_q.push_back(la); ref_last_dm = 1'b0;
            exp_cyc = 2 + la;
        end else begin
            exp_cyc = 0;
        end
        if (dm_en) begin
            if (bw == BWEB_READ) ref_dm_dout = ref_rd(da);
            else ref_mem[da] = merge(ref_rd(da), bw, din);
        end
        if (im_en) begin
            ref_im_dout = ref_rd(pc);
            ref_im_addr = pc;
        end
        if (im_en || dm_en) push_res();
        @(posedge clk);
        #1;
        bus.im_request_i   = im_en;
        bus.im_pc_i        = pc;
        bus.dm_request_i   = dm_en;
        bus.dm_addr_i      = da;
        bus.dm_bit_write_i = bw;
        bus.dm_din_i       = din;
        wait_round(cyc);
        if (chk_cyc) chk("round_cycles", cyc, exp_cyc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bus.im_request_i   = 1'b0;
        bus.im_pc_i        = 32'h0;
        bus.dm_request_i   = 1'b0;
        bus.dm_bit_write_i = BWEB_READ;
        bus.dm_addr_i      = 32'h0;
        bus.dm_din_i       = 32'h0;
        env_mem[32'h100] = 32'h00500093;
        ref_mem[32'h100] = 32'h00500093;
        ref_im_dout = 32'h0; ref_im_addr = 32'h0; ref_dm_dout = 32'h0;
        ref_last_dm = 1'b0;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", {31'h0, bus.mem_req_o}, 32'h0);
        chk("rst_mem_bweb", {28'h0, bus.mem_bweb_o}, 32'hF);
        chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("rst_im_dout", bus.im_dout_o, 32'h0);
        chk("rst_dm_dout", bus.dm_dout_o, 32'h0);
        chk("rst_waits", {30'h0, bus.im_wait_o, bus.dm_wait_o}, 32'h0);
        rst = 1'b1;

        // Directed cases
        run_round(1'b1, 32'h100, 1'b0, 32'h0, BWEB_READ, 32'h0, 2, 0, 1'b1);
        run_round(1'b1, 32'h104, 1'b1, 32'h2000, BWEB_READ, 32'h0, 1, 0, 1'b1);
        run_round(1'b0, 32'h0, 1'b1, 32'h2004, 4'b1100, 32'hDEADBEEF, 0, 0, 1'b1);
        run_round(1'b0, 32'h0, 1'b1, 32'h2004, BWEB_READ, 32'h0, 1, 0, 1'b1);
        run_round(1'b1, 32'h108, 1'b1, 32'h2008, BWEB_READ, 32'h0, 0, 2, 1'b1);
        run_round(1'b1, 32'h10C, 1'b1, 32'h200C, BWEB_READ, 32'h0, 1, 1, 1'b1);

        // Spurious ready while idle must not disturb anything
        @(posedge clk);
        #1;
        bus.im_request_i = 1'b0;
        bus.dm_request_i = 1'b0;
        @(posedge clk);
        #1;
        spur = 1'b1;
        repeat (3) @(negedge clk);
        chk("spur_im_dout", bus.im_dout_o, ref_im_dout);
        chk("spur_im_addr", bus.im_addr_o, ref_im_addr);
        chk("spur_dm_dout", bus.dm_dout_o, ref_dm_dout);
        chk("spur_mem_req", {31'h0, bus.mem_req_o}, 32'h0);
        run_round(1'b1, 32'h110, 1'b0, 32'h0, BWEB_READ, 32'h0, 0, 0, 1'b1);

        // Randomized rounds
        for (int k = 0; k < 80; k++) begin
            logic [3:0] bw;
            bw = ($urandom_range(0, 1) == 0) ? BWEB_READ : 4'($urandom_range(0, 14));
            run_round(1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 63)),
                      1'($urandom_range(0, 1)), 32'h2000 + 32'(4 * $urandom_range(0, 63)),
                      bw, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
        end

        // Reset in the middle of a data access, then the access restarts
        @(posedge clk);
        #1;
        hold = 1'b1;
        ref_im_dout = 32'h0; ref_im_addr = 32'h0; ref_last_dm = 1'b1;
        ref_dm_dout = ref_rd(32'h2010);
        exp_mem_q.push_back('{32'h2010, BWEB_READ, 32'h0, 1'b1});
        exp_mem_q.push_back('{32'h2010, BWEB_READ, 32'h0, 1'b1});
        lat_q.push_back(0);
        lat_q.push_back(1);
        push_res();
        bus.im_request_i   = 1'b0;
        bus.dm_request_i   = 1'b1;
        bus.dm_addr_i      = 32'h2010;
        bus.dm_bit_write_i = BWEB_READ;
        bus.dm_din_i       = 32'h0;
        repeat (3) @(negedge clk);
        chk("pre_rst_mem_req", {31'h0, bus.mem_req_o}, 32'h1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_mem_req", {31'h0, bus.mem_req_o}, 32'h0);
        chk("mid_rst_mem_bweb", {28'h0, bus.mem_bweb_o}, 32'hF);
        chk("mid_rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("mid_rst_im_dout", bus.im_dout_o, 32'h0);
        chk("mid_rst_im_addr", bus.im_addr_o, 32'h0);
        chk("mid_rst_dm_dout", bus.dm_dout_o, 32'h0);
        chk("mid_rst_dm_wait", {31'h0, bus.dm_wait_o}, 32'h1);
        rst = 1'b1;
        hold = 1'b0;
        wait_round(cyc);
        run_round(1'b1, 32'h114, 1'b1, 32'h2014, BWEB_READ, 32'h0, 0, 0, 1'b1);

        @(posedge clk);
        #1;
        bus.im_request_i = 1'b0;
        bus.dm_request_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("mem_q_empty", 32'(exp_mem_q.size()), 32'h0);
        chk("res_q_empty", 32'(exp_res_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
